// File: rtl/param_ram_pkg.sv
// Shared definitions for the neuron-parameter RAM and its loader.
package param_ram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } ram_state_e;

  localparam int RAM_DATA_W = 16;
  localparam int RAM_DEPTH  = 8;

endpackage

// File: rtl/param_ram_clr_seq.sv
// Clear sequencer: owns the RAM state, sweeps every word to zero after reset
// or on request, and exposes the sweep as a write port.
module param_ram_clr_seq
  import param_ram_pkg::*;
#(
  parameter int DEPTH  = RAM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      S_CLEAR: begin
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = S_RUN;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      S_RUN: begin
        if (clr_req) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign busy     = (state_q == S_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/param_ram_sync.sv
// Clocked neuron-parameter RAM: one write and one registered read per cycle,
// write-through on collision, hardware clear sweep and out-of-range flagging.
module param_ram_sync
  import param_ram_pkg::*;
#(
  parameter int                DATA_W   = RAM_DATA_W,
  parameter int                DEPTH    = RAM_DEPTH,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] IDLE_VAL = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  param_ram_clr_seq #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  logic accept, wr_in_range, rd_in_range;

  // A clear request in S_RUN wins over any access issued in the same cycle.
  assign accept      = ~busy & ~clr_req;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (accept && wr_en && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    rd_valid_d = accept & rd_en;
    rd_data_d  = IDLE_VAL;
    if (rd_valid_d && rd_in_range) begin
      if (wr_en && (wr_addr == rd_addr)) rd_data_d = wr_data;
      else                               rd_data_d = mem_q[rd_addr];
    end

    addr_err_d = addr_err_q;
    if (!busy && clr_req) begin
      addr_err_d = 1'b0;
    end else if (accept && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range))) begin
      addr_err_d = 1'b1;
    end
  end

  // NOTE: the array has no reset; the clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= IDLE_VAL;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_param_ram_sync.sv
// Scoreboard bench for param_ram_sync: a DEPTH=8 instance and a DEPTH=6
// instance share stimulus, with accesses steered to one of them at a time.
module tb_param_ram_sync;

  logic        clk = 1'b0;
  logic        rst, clr_req, wr_en, rd_en, sel_b;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;

  logic [15:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, a_busy, a_addr_err;
  logic        b_rd_valid, b_busy, b_addr_err;

  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_on = 1'b0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  param_ram_sync #(.DATA_W(16), .DEPTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .wr_en(wr_en & ~sel_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en & ~sel_b), .rd_addr(rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy), .addr_err(a_addr_err)
  );

  param_ram_sync #(.DATA_W(16), .DEPTH(6)) u_dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .wr_en(wr_en & sel_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en & sel_b), .rd_addr(rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy), .addr_err(b_addr_err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; ev pushes an expected read result.
  task automatic cyc(input bit r, input bit clr, input bit we, input logic [2:0] wa,
                     input logic [15:0] wd, input bit re, input logic [2:0] ra,
                     input bit ev, input logic [15:0] ed);
    rst = r; clr_req = clr; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (ev) begin
      if (sel_b) qb.push_back(ed);
      else       qa.push_back(ed);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, 16'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cyc(0, 0, 1, a, d, 0, 3'd0, 0, 16'h0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e);
    cyc(0, 0, 0, 3'd0, 16'h0, 1, a, 1, e);
  endtask

  // Requests issued while busy must all be dropped.
  task automatic busy_cycle(input string name, input logic bsy);
    check(name, sel_b ? b_busy : a_busy, 16'(bsy));
    cyc(0, 0, 1, 3'd0, 16'hDEAD, 1, 3'd1, 0, 16'h0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (a_rd_valid) begin
        if (qa.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_spurious_valid: got rd_valid=1 data %h, expected rd_valid=0", a_rd_data);
        end else check("a_rd_data", a_rd_data, qa.pop_front());
      end else check("a_idle_data", a_rd_data, 16'hFFFF);
      if (b_rd_valid) begin
        if (qb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_spurious_valid: got rd_valid=1 data %h, expected rd_valid=0", b_rd_data);
        end else check("b_rd_data", b_rd_data, qb.pop_front());
      end else check("b_idle_data", b_rd_data, 16'hFFFF);
    end
  end

  initial begin
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; sel_b = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;

    // Reset sweep: busy for exactly 8 samples, requests dropped.
    cyc(1, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, 16'h0);
    mon_on = 1'b1;
    check("rst_addr_err", a_addr_err, 16'h0);
    for (int i = 0; i < 8; i++) busy_cycle("rst_sweep_busy", 1'b1);
    check("rst_sweep_done", a_busy, 16'h0);
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000);

    // Write and readback with idle cycles between.
    wr(3'd3, 16'h1234);
    wr(3'd7, 16'hBEEF);
    idle(1);
    rd(3'd3, 16'h1234);
    idle(1);
    rd(3'd7, 16'hBEEF);
    idle(1);

    // Collision bypass, plus a non-colliding pair in the same cycle.
    cyc(0, 0, 1, 3'd2, 16'hA5A5, 1, 3'd2, 1, 16'hA5A5);
    cyc(0, 0, 1, 3'd5, 16'h5A5A, 1, 3'd3, 1, 16'h1234);
    rd(3'd2, 16'hA5A5);
    rd(3'd5, 16'h5A5A);
    check("a_addr_err_quiet", a_addr_err, 16'h0);

    // Clear mid-operation; a second clr_req during the sweep is ignored.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1111 * 16'(i + 1));
    rd(3'd6, 16'h7777);
    cyc(0, 1, 1, 3'd1, 16'h9999, 1, 3'd6, 0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        check("clr_sweep_busy", a_busy, 16'h1);
        cyc(0, 1, 0, 3'd0, 16'h0, 1, 3'd2, 0, 16'h0);
      end else busy_cycle("clr_sweep_busy", 1'b1);
    end
    check("clr_sweep_done", a_busy, 16'h0);
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000);

    // Reset with a read in flight, then reset again at sweep cycle 4.
    cyc(1, 0, 0, 3'd0, 16'h0, 1, 3'd3, 0, 16'h0);
    for (int i = 0; i < 4; i++) busy_cycle("rst2_sweep_busy", 1'b1);
    check("rst2_sweep_busy", a_busy, 16'h1);
    cyc(1, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, 16'h0);
    for (int i = 0; i < 8; i++) busy_cycle("rst3_sweep_busy", 1'b1);
    check("rst3_sweep_done", a_busy, 16'h0);
    rd(3'd0, 16'h0000);
    rd(3'd7, 16'h0000);

    // Out-of-range on the DEPTH=6 instance.
    sel_b = 1'b1;
    for (int i = 0; i < 6; i++) wr(3'(i), 16'h0011 * 16'(i + 1));
    check("b_addr_err_clean", b_addr_err, 16'h0);
    wr(3'd7, 16'h0055);
    check("b_addr_err_wr", b_addr_err, 16'h1);
    rd(3'd7, 16'hFFFF);
    for (int i = 0; i < 6; i++) rd(3'(i), 16'h0011 * 16'(i + 1));
    rd(3'd6, 16'hFFFF);
    check("b_addr_err_sticky", b_addr_err, 16'h1);
    cyc(0, 1, 0, 3'd0, 16'h0, 0, 3'd0, 0, 16'h0);
    check("b_addr_err_clr", b_addr_err, 16'h0);
    for (int i = 0; i < 6; i++) busy_cycle("b_sweep_busy", 1'b1);
    check("b_sweep_done", b_busy, 16'h0);
    rd(3'd5, 16'h0000);
    idle(2);

    check("a_pending_reads", 16'(qa.size()), 16'h0);
    check("b_pending_reads", 16'(qb.size()), 16'h0);
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_ram_sync.md
# param_ram_sync

Clocked, parametrised successor to the neuron-parameter RAM. Holds per-neuron weights and thresholds for the asynchronous neural circuits. Provides:
- one write port and one read port in the same cycle;
- registered reads with a valid flag;
- write-through on address collision;
- a hardware clear sequencer that zeroes every word after reset or on request;
- out-of-range address detection for non-power-of-two depths.

## Interface
Parameters:
- DATA_W, 16, word width in bits
- DEPTH, 8, number of words (any value ≥ 2)
- ADDR_W, $clog2(DEPTH), address width
- IDLE_VAL, all ones of DATA_W, value driven on rd_data when no read completes

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- clr_req  in  1  single-cycle pulse; starts a clear sweep
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data holds a completed read this cycle
- busy  out  1  clear sweep in progress; requests are dropped
- addr_err  out  1  sticky out-of-range flag

## Operation
- **States:**
  - S_CLEAR: sweeping; clr_ptr counts 0..DEPTH-1 and writes 0 to mem[clr_ptr] each cycle.
  - S_RUN: normal access.
- **Reset.** When rst is sampled high:
  - next state is S_CLEAR with clr_ptr=0, busy=1, rd_valid=0, rd_data=IDLE_VAL, addr_err=0.
  - Memory contents are not cleared by rst itself; the sweep clears them.
- **Sweep end.** In S_CLEAR, when clr_ptr==DEPTH-1, word DEPTH-1 is written and the next state is S_RUN.
- **Clear request.**
  - clr_req in S_RUN: next state is S_CLEAR with clr_ptr=0; addr_err is also cleared.
  - clr_req in S_CLEAR: ignored. The sweep is not restarted.
- **Dropped requests.** In S_CLEAR, wr_en and rd_en are ignored:
  - no memory update and no addr_err update;
  - rd_valid=0 and rd_data=IDLE_VAL.
- **Write (S_RUN).** wr_en with wr_addr<DEPTH gives mem[wr_addr] ← wr_data at the edge.
- **Read (S_RUN).** rd_en with rd_addr<DEPTH gives, at the next edge, rd_valid=1 and rd_data=mem[rd_addr].
- **Collision.** rd_en and wr_en in the same cycle with equal in-range addresses: rd_data = wr_data (new data, write-through).
- **Out of range.** Address ≥ DEPTH:
  - a write is discarded; a read completes with rd_valid=1 and rd_data=IDLE_VAL;
  - either case sets addr_err=1, which holds until rst or the next clr_req.
- **No read.** A cycle without a completing read gives rd_valid=0 and rd_data=IDLE_VAL on the next edge.
- **Priority (highest first):** rst, then clr_req, then normal access. clr_req in S_RUN takes effect over a read or write issued in the same cycle: that read or write is dropped.

## Timing
- Read latency is 1 cycle. rd_valid/rd_data are registered; there is no combinational path from inputs to outputs.
- Write is visible to a read issued in the same cycle (bypass) and to any later read.
- Clear sweep lasts exactly DEPTH cycles with busy=1.
  - The first request accepted after rst deasserts is in the cycle where busy=0. That is cycle DEPTH+1 after the rst edge.
- busy is driven directly from the state register (busy=1 ⇔ S_CLEAR).
- Throughput in S_RUN: one read and one write every cycle.
- **rst mid-sweep:** restarts the sweep at clr_ptr=0.
- **rst mid-read:** the pending rd_valid is squashed to 0.

## Structure
- Shared package param_ram_pkg holds:
  - the state typedef {S_CLEAR, S_RUN};
  - the default DATA_W/DEPTH constants, shared with the neuron parameter loader.
- Sub-module param_ram_clr_seq holds the state register, clr_ptr counter and busy output, and supplies the clear write port.
- The top level muxes the clear write against the user write, and holds the memory array, bypass and read register.

## Test plan
- **Reset sweep.** rst high 1 cycle, DEPTH=8.
  - busy=1 for exactly 8 cycles.
  - Then read all addresses → rd_valid=1, rd_data=0 each, one cycle after each rd_en.
- **Write/readback.** Write 0x1234@3 and 0xBEEF@7, then read 3 and 7 → 0x1234, 0xBEEF; rd_data=0xFFFF on idle cycles.
- **Collision.** Same cycle: wr 0xA5A5@2 and rd @2 → next cycle rd_data=0xA5A5, rd_valid=1.
- **Out of range.** DEPTH=6: write 0x0055@7, read @7.
  - rd_valid=1, rd_data=0xFFFF, addr_err=1.
  - mem[0..5] unchanged.
  - addr_err clears after clr_req.
- **Clear mid-operation.** Fill mem, then pulse clr_req together with wr_en.
  - The write is dropped and busy=1 for DEPTH cycles.
  - Requests during busy give rd_valid=0.
  - Afterwards all words read 0.
- **Reset during sweep.** Assert rst at sweep cycle 4 → busy stays high DEPTH more cycles; no request is accepted earlier.
